// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and constants for the direct-mapped instruction cache.
//   state_t        : fill controller states (IDLE, MEM_READ, UPDATE)
//   TAG_W/IDX_W/OFF_W : fields of the word address ADDRESS[9:2]
//   BLOCK_W        : cache line / memory block width in bits
//   split_addr()   : breaks ADDRESS[9:2] into {tag, index, word offset}
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;

  // Width of the word-address slice ADDRESS[9:2].
  localparam int WADDR_W = TAG_W + IDX_W + OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [WADDR_W-1:0] word_addr);
    return addr_fields_t'(word_addr);
  endfunction

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Bundles the CPU fetch port and the instruction-memory block port of icache.
//   CPU side : READ, ADDRESS (in to cache); INSTRUCTION, BUSYWAIT (out)
//   Mem side : MEM_READ, MEM_ADDRESS (out of cache); MEM_READDATA,
//              MEM_BUSYWAIT (in)
// Modports:
//   slave  : the cache's view
//   master : the CPU + memory environment's view
// -----------------------------------------------------------------------------
interface icache_if #(
  parameter int MEM_ADDR_W = 6
) ();

  logic                  READ;
  logic [31:0]           ADDRESS;
  logic [31:0]           INSTRUCTION;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
  logic [127:0]          MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport slave (
    input  READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

endinterface

// File: rtl/icache_word_sel.sv
// -----------------------------------------------------------------------------
// icache_word_sel
// 4:1 selector picking one 32-bit word out of a 128-bit cache line.
//   block : cache line, word k is block[32k+31:32k]
//   off   : word offset ADDRESS[3:2]
//   word  : selected word
// -----------------------------------------------------------------------------
module icache_word_sel
  import icache_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  input  logic [OFF_W-1:0]   off,
  output logic [WORD_W-1:0]  word
);

  assign word = block[off*WORD_W +: WORD_W];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, read-only instruction cache between the CPU fetch port and a
// 128-bit-wide instruction memory. Hits return INSTRUCTION combinationally in
// the same cycle; a miss raises BUSYWAIT, reads the block from memory and
// installs it, after which the held PC hits.
//
// Ports:
//   CLK          : clock, rising edge
//   RESET        : asynchronous, active-high reset
//   bus          : icache_if.slave (READ, ADDRESS, INSTRUCTION, BUSYWAIT,
//                  MEM_READ, MEM_ADDRESS, MEM_READDATA, MEM_BUSYWAIT)
//   HIT_COUNT    : 16-bit saturating hit counter   (ICACHE_STATS_EN only)
//   MISS_COUNT   : 16-bit saturating miss counter  (ICACHE_STATS_EN only)
//
// Build option: define ICACHE_STATS_EN to add the hit/miss counters.
// -----------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int MEM_ADDR_W = 6,
  parameter int NUM_LINES  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  // ---------------------------------------------------------------------------
  // Address decode and lookup
  // ---------------------------------------------------------------------------
  addr_fields_t req;
  assign req = split_addr(bus.ADDRESS[WADDR_W+1:2]);

  // Upper address bits and the byte offset play no part in the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ADDRESS[31:WADDR_W+2], bus.ADDRESS[1:0]};

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_mem [NUM_LINES];

  logic hit;
  assign hit = valid[req.idx] && (tag_mem[req.idx] == req.tag);

  logic [WORD_W-1:0] sel_word;

  icache_word_sel u_word_sel (
    .block (data_mem[req.idx]),
    .off   (req.off),
    .word  (sel_word)
  );

  assign bus.INSTRUCTION = sel_word;

  // ---------------------------------------------------------------------------
  // Fill controller
  // ---------------------------------------------------------------------------
  state_t                state, state_nxt;
  logic [MEM_ADDR_W-1:0] fill_addr;   // latched {tag, index} of the miss
  logic [BLOCK_W-1:0]    fill_data;   // block captured from memory
  logic                  start_fill;
  logic                  capture;
  logic                  busy;
  logic                  mem_rd;

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  assign fill_idx = fill_addr[IDX_W-1:0];
  assign fill_tag = fill_addr[MEM_ADDR_W-1:IDX_W];

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    mem_rd     = 1'b0;
    start_fill = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.READ && !hit) begin
          busy       = 1'b1;
          start_fill = 1'b1;
          state_nxt  = MEM_READ;
        end
      end
      MEM_READ: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          capture   = 1'b1;
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MEM_READ follows the state register, so an asynchronous reset drops it at
  // once; BUSYWAIT is additionally masked so a held PC cannot stall in reset.
  assign bus.BUSYWAIT    = busy & ~RESET;
  assign bus.MEM_READ    = mem_rd;
  assign bus.MEM_ADDRESS = fill_addr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      valid     <= '0;
      fill_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start_fill) fill_addr <= {req.tag, req.idx};
      if (state == UPDATE) valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the cleared valid bits already
  // make their contents unobservable, and keeping them reset-free lets them
  // map onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge CLK) begin
    if (capture) fill_data <= bus.MEM_READDATA;
    if (state == UPDATE) begin
      data_mem[fill_idx] <= fill_data;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional hit/miss statistics
  // ---------------------------------------------------------------------------
`ifdef ICACHE_STATS_EN
  // The IDLE cycle right after UPDATE completes a miss, not a fresh hit.
  logic prev_update;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_update <= 1'b0;
      HIT_COUNT   <= '0;
      MISS_COUNT  <= '0;
    end else begin
      prev_update <= (state == UPDATE);
      if (state == IDLE && bus.READ && hit && !prev_update && HIT_COUNT != 16'hFFFF)
        HIT_COUNT <= HIT_COUNT + 16'd1;
      if (start_fill && MISS_COUNT != 16'hFFFF)
        MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
// Self-checking bench for icache. A driver issues fetches and pushes the
// expected instruction and stall length into a scoreboard queue; a monitor
// pops and compares whenever the cache completes a fetch (READ & ~BUSYWAIT).
// The reference model is a set of valid/tag arrays plus a flat 1 KiB memory:
// the expected instruction is simply the memory word, and a miss costs L+3.
// -----------------------------------------------------------------------------
module tb_icache;

  logic CLK = 1'b0;
  logic RESET;

  icache_if #(.MEM_ADDR_W(6)) bus ();

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  icache #(.MEM_ADDR_W(6), .NUM_LINES(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [127:0] mem [64];
  int           mem_lat = 0;
  bit           ref_valid [8];
  logic [2:0]   ref_tag   [8];
  int           ref_hits   = 0;
  int           ref_misses = 0;
  logic [5:0]   fill_q [$];     // block addresses memory is expected to see

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] instr;
    int          stall;
  } exp_t;

  exp_t exp_q [$];

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    logic [127:0] blk;
    blk = mem[a[9:4]];
    return blk[a[3:2]*32 +: 32];
  endfunction

  function automatic bit ref_lookup(input logic [9:0] a);
    return ref_valid[a[6:4]] && (ref_tag[a[6:4]] == a[9:7]);
  endfunction

  task automatic ref_fill(input logic [9:0] a);
    ref_valid[a[6:4]] = 1'b1;
    ref_tag[a[6:4]]   = a[9:7];
    ref_misses++;
    fill_q.push_back(a[9:4]);
  endtask

  // ---------------------------------------------------------------------------
  // Instruction memory: busy for mem_lat MEM_READ cycles, then returns data.
  // ---------------------------------------------------------------------------
  int mem_cnt = 0;

  always @(negedge CLK) begin
    if (bus.MEM_READ) begin
      mem_cnt++;
      check("fill_pending", 64'(fill_q.size() != 0), 64'd1);
      if (fill_q.size() != 0) check("mem_address", 64'(bus.MEM_ADDRESS), 64'(fill_q[0]));
      if (mem_cnt > mem_lat) begin
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
        if (fill_q.size() != 0) void'(fill_q.pop_front());
      end else begin
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = {4{$urandom}};
      end
    end else begin
      mem_cnt          = 0;
      bus.MEM_BUSYWAIT = 1'b1;
      bus.MEM_READDATA = {4{$urandom}};
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: counts stall cycles and checks each completed fetch.
  // ---------------------------------------------------------------------------
  int stall_cnt = 0;

  always @(negedge CLK) begin
    if (RESET || !bus.READ) begin
      stall_cnt = 0;
    end else if (bus.BUSYWAIT) begin
      stall_cnt++;
    end else begin
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("instr@%h", e.addr), 64'(bus.INSTRUCTION), 64'(e.instr));
        check($sformatf("stall@%h", e.addr), 64'(stall_cnt), 64'(e.stall));
      end
      stall_cnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic drive_addr(input logic [9:0] a);
    logic [31:0] r;
    r      = $urandom;
    r[9:2] = a[9:2];
    bus.ADDRESS = r;
  endtask

  task automatic wait_not_busy(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge CLK);
      if (!bus.BUSYWAIT) done = 1'b1;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic wait_mem_read(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (bus.MEM_READ) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic fetch(input logic [9:0] a);
    exp_t e;
    bit   hit;
    hit     = ref_lookup(a);
    e.addr  = a;
    e.instr = mem_word(a);
    e.stall = hit ? 0 : mem_lat + 3;
    if (hit) ref_hits++;
    else     ref_fill(a);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    bus.READ = 1'b1;
    drive_addr(a);
    wait_not_busy("fetch_done");
  endtask

  task automatic check_stats();
    @(posedge CLK);
    #1;
    bus.READ = 1'b0;
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    check("hit_count", 64'(hit_count), 64'(ref_hits));
    check("miss_count", 64'(miss_count), 64'(ref_misses));
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[0] = 128'h33333333_22222222_11111111_00000000;
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
    end

    // Reset: a pending miss must not raise BUSYWAIT while RESET is high.
    RESET       = 1'b1;
    bus.READ    = 1'b1;
    bus.ADDRESS = 32'h0000_0000;
    mem_lat     = 4;
    repeat (2) @(negedge CLK);
    check("rst_busywait", 64'(bus.BUSYWAIT), 64'd0);
    check("rst_mem_read", 64'(bus.MEM_READ), 64'd0);
    check("rst_mem_address", 64'(bus.MEM_ADDRESS), 64'd0);
    bus.READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
`endif

    // First fetch misses with L=4: 7 stall cycles, block 0 from memory.
    fetch(10'h000);
    // Same-block hits.
    fetch(10'h004);
    fetch(10'h008);
    fetch(10'h00C);
    // Conflict miss on index 0, then stats are 3 hits / 2 misses.
    mem_lat = 1;
    fetch(10'h080);
    check_stats();
    // Old block 0 was evicted; L=0 boundary on its refill.
    mem_lat = 0;
    fetch(10'h000);

    // Address change mid-fill: fill of 0x080 completes, then 0x010 misses.
    begin
      exp_t e;
      mem_lat = 2;
      e.addr  = 10'h010;
      e.instr = mem_word(10'h010);
      e.stall = 2 * (mem_lat + 3);
      ref_fill(10'h080);
      ref_fill(10'h010);
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      bus.READ = 1'b1;
      drive_addr(10'h080);
      wait_mem_read("midchg_mem_read");
      #1;
      drive_addr(10'h010);
      wait_not_busy("midchg_done");
    end
    fetch(10'h080);   // index 0 was written by the fill above

    // Dropping READ mid-fill does not abort the fill.
    mem_lat = 3;
    ref_fill(10'h0C0);
    @(posedge CLK);
    #1;
    bus.READ = 1'b1;
    drive_addr(10'h0C0);
    wait_mem_read("drop_mem_read");
    #1;
    bus.READ = 1'b0;
    @(negedge CLK);
    check("drop_fill_continues", 64'(bus.MEM_READ), 64'd1);
    begin
      bit ended = 1'b0;
      for (int k = 0; k < 20 && !ended; k++) begin
        @(negedge CLK);
        if (!bus.MEM_READ) ended = 1'b1;
      end
      check("drop_fill_ends", 64'(ended), 64'd1);
    end
    repeat (2) @(negedge CLK);
    fetch(10'h0C4);

    // READ=0 in IDLE with a missing address: no fill, no stall.
    @(posedge CLK);
    #1;
    bus.READ = 1'b0;
    drive_addr(10'h3F0);
    repeat (3) begin
      @(negedge CLK);
      check("idle_busywait", 64'(bus.BUSYWAIT), 64'd0);
      check("idle_mem_read", 64'(bus.MEM_READ), 64'd0);
    end
    check_stats();

    // Reset during MEM_READ: MEM_READ falls without a clock edge.
    mem_lat = 5;
    fill_q.push_back(6'h0A);
    @(posedge CLK);
    #1;
    bus.READ = 1'b1;
    drive_addr(10'h0A0);
    wait_mem_read("rstmid_mem_read");
    #1;
    RESET = 1'b1;
    #1;
    check("rstmid_mem_read_low", 64'(bus.MEM_READ), 64'd0);
    check("rstmid_busywait_low", 64'(bus.BUSYWAIT), 64'd0);
    bus.READ = 1'b0;
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
    fill_q.delete();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    fetch(10'h080);   // all lines invalid again: must miss
    check_stats();

    // Randomized traffic over two tags so hits and conflicts both occur.
    for (int i = 0; i < 250; i++) begin
      logic [9:0] a;
      mem_lat = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge CLK);
        #1;
        bus.READ = 1'b0;
      end
      a[9:7] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      a[6:4] = 3'($urandom_range(0, 7));
      a[3:0] = 4'($urandom_range(0, 15));
      fetch(a);
    end
    check_stats();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("fills_drained", 64'(fill_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
